// File: rtl/occupancy_pattern_gen.sv
// Parking-lot sensor pattern transmitter: queues enter/exit commands, drives the
// two-sensor pulse sequence on btn and tracks the expected occupancy count.
module occupancy_pattern_gen #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cmd_valid,
  input  logic                          cmd_dir,
  output logic                          cmd_ready,
  output logic [3:0]                    btn,
  output logic                          busy,
  output logic                          done,
  output logic [3:0]                    expected_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int LW      = AW + 1;
  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, PH1, PH2, PH3, GAP} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic              dir_q;
  logic [FIFO_DEPTH-1:0] fifo_mem;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push;
  logic              pop;
  logic              head_dir;

  assign cmd_ready = (fifo_level != LW'(FIFO_DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == IDLE) && (fifo_level != '0);
  assign head_dir  = fifo_mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_mem   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= cmd_dir;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        fifo_level <= fifo_level + 1'b1;
      else if (pop && !push)
        fifo_level <= fifo_level - 1'b1;
    end
  end

  // btn is loaded with the next phase's pattern on each transition so it only moves on phase boundaries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      dir_q          <= 1'b0;
      btn            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      expected_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            state <= PH1;
            dir_q <= head_dir;
            cnt   <= HOLD_LOAD;
            btn   <= head_dir ? 4'b0010 : 4'b0001;
            busy  <= 1'b1;
          end
        end
        PH1: begin
          if (cnt == '0) begin
            state <= PH2;
            cnt   <= HOLD_LOAD;
            btn   <= 4'b0011;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        PH2: begin
          if (cnt == '0) begin
            state <= PH3;
            cnt   <= HOLD_LOAD;
            btn   <= dir_q ? 4'b0001 : 4'b0010;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        PH3: begin
          if (cnt == '0) begin
            state <= GAP;
            cnt   <= GAP_LOAD;
            btn   <= 4'b0000;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            if (!dir_q)
              expected_count <= expected_count + 1'b1;
            else if (expected_count != '0)
              expected_count <= expected_count - 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          btn   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
